// File: rtl/conv_window_addr_gen.sv
// Sliding-window read-address generator: scans every k x k window of an n x m image.
// Optional CONV_ADDR_STRIDE_EN adds a 2-bit stride input (otherwise stride is fixed at 1).
module conv_window_addr_gen #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  n,
  input  logic [DIM_W-1:0]  m,
  input  logic [DIM_W-1:0]  k,
  input  logic [ADDR_W-1:0] base,
`ifdef CONV_ADDR_STRIDE_EN
  input  logic [1:0]        stride,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              win_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned CW = DIM_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]  n_q, m_q, k_q, n_d, m_d, k_d;
  logic [1:0]        stride_q, stride_d, stride_in;
  logic [DIM_W-1:0]  r_q, c_q, ky_q, kx_q, r_d, c_d, ky_d, kx_d;
  // line_ptr = base + r*n, win_ptr = line_ptr + c, row_ptr = win_ptr + ky*n
  logic [ADDR_W-1:0] line_ptr_q, win_ptr_q, row_ptr_q, addr_q;
  logic [ADDR_W-1:0] line_ptr_d, win_ptr_d, row_ptr_d, addr_d;
  logic              win_last_q, valid_q, busy_q, done_q, cfg_err_q;
  logic              win_last_d, valid_d, busy_d, done_d, cfg_err_d;

  logic              cfg_bad_c;
  logic [ADDR_W-1:0] n_a, stride_a, line_step;
  logic [DIM_W-1:0]  k_m1;

`ifdef CONV_ADDR_STRIDE_EN
  assign stride_in = stride;
`else
  assign stride_in = 2'd1;
`endif

  assign cfg_bad_c = (k == '0) || (k > n) || (k > m) || (stride_in == 2'd0);
  assign n_a       = ADDR_W'(n_q);
  assign stride_a  = ADDR_W'(stride_q);
  assign line_step = (stride_q[0] ? n_a : '0) + (stride_q[1] ? ADDR_W'(n_a << 1) : '0);
  assign k_m1      = k_q - DIM_W'(1);

  // Next-state and datapath: advance kx, then ky, then c, then r on each handshake
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    m_d        = m_q;
    k_d        = k_q;
    stride_d   = stride_q;
    r_d        = r_q;
    c_d        = c_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    line_ptr_d = line_ptr_q;
    win_ptr_d  = win_ptr_q;
    row_ptr_d  = row_ptr_q;
    addr_d     = addr_q;
    win_last_d = win_last_q;
    cfg_err_d  = cfg_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad_c) begin
            state_d   = DONE;
            cfg_err_d = 1'b1;
          end else begin
            state_d    = RUN;
            cfg_err_d  = 1'b0;
            n_d        = n;
            m_d        = m;
            k_d        = k;
            stride_d   = stride_in;
            r_d        = '0;
            c_d        = '0;
            ky_d       = '0;
            kx_d       = '0;
            line_ptr_d = base;
            win_ptr_d  = base;
            row_ptr_d  = base;
            addr_d     = base;
            win_last_d = (k == DIM_W'(1));
          end
        end
      end
      RUN: begin
        if (addr_ready) begin
          if (kx_q != k_m1) begin
            kx_d   = kx_q + DIM_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else if (ky_q != k_m1) begin
            kx_d      = '0;
            ky_d      = ky_q + DIM_W'(1);
            row_ptr_d = row_ptr_q + n_a;
            addr_d    = row_ptr_q + n_a;
          end else if (CW'(c_q) + CW'(stride_q) + CW'(k_q) <= CW'(n_q)) begin
            kx_d      = '0;
            ky_d      = '0;
            c_d       = c_q + DIM_W'(stride_q);
            win_ptr_d = win_ptr_q + stride_a;
            row_ptr_d = win_ptr_q + stride_a;
            addr_d    = win_ptr_q + stride_a;
          end else if (CW'(r_q) + CW'(stride_q) + CW'(k_q) <= CW'(m_q)) begin
            kx_d       = '0;
            ky_d       = '0;
            c_d        = '0;
            r_d        = r_q + DIM_W'(stride_q);
            line_ptr_d = line_ptr_q + line_step;
            win_ptr_d  = line_ptr_q + line_step;
            row_ptr_d  = line_ptr_q + line_step;
            addr_d     = line_ptr_q + line_step;
          end else begin
            state_d = DONE;
          end
          win_last_d = (state_d == RUN) && (ky_d == k_m1) && (kx_d == k_m1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      m_q        <= '0;
      k_q        <= '0;
      stride_q   <= '0;
      r_q        <= '0;
      c_q        <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      line_ptr_q <= '0;
      win_ptr_q  <= '0;
      row_ptr_q  <= '0;
      addr_q     <= '0;
      win_last_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      m_q        <= m_d;
      k_q        <= k_d;
      stride_q   <= stride_d;
      r_q        <= r_d;
      c_q        <= c_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      line_ptr_q <= line_ptr_d;
      win_ptr_q  <= win_ptr_d;
      row_ptr_q  <= row_ptr_d;
      addr_q     <= addr_d;
      win_last_q <= win_last_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign win_last   = win_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench for conv_window_addr_gen: nested-loop reference model feeds a queue
// that a handshake monitor drains; covers stride when CONV_ADDR_STRIDE_EN is defined.
module tb_conv_window_addr_gen;

  logic       clk, rst, start, addr_ready;
  logic [7:0] n, m, k, base, addr;
  logic       addr_valid, win_last, busy, done, cfg_err;
`ifdef CONV_ADDR_STRIDE_EN
  logic [1:0] stride;
`endif

  conv_window_addr_gen #(.ADDR_W(8), .DIM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .m(m), .k(k), .base(base),
`ifdef CONV_ADDR_STRIDE_EN
    .stride(stride),
`endif
    .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .win_last(win_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int n_chk = 0, n_pass = 0;
  int hs_cnt = 0, valid_cyc = 0, done_cyc = 0;
  bit rdy_rnd = 0;
  logic [8:0] exp_q[$];   // {win_last, addr}

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Reference: every window position in scan order, addresses mod 256
  task automatic model(input int mn, input int mm, input int mk, input int mb, input int ms);
    if (mk == 0 || mk > mn || mk > mm || ms == 0) return;
    for (int r = 0; r + mk <= mm; r += ms)
      for (int c = 0; c + mk <= mn; c += ms)
        for (int ky = 0; ky < mk; ky++)
          for (int kx = 0; kx < mk; kx++) begin
            int a;
            a = (mb + (r + ky) * mn + c + kx) % 256;
            exp_q.push_back({(ky == mk - 1 && kx == mk - 1) ? 1'b1 : 1'b0, 8'(a)});
          end
  endtask

  // Consumer ready: always high or pseudo-random, changed just after each rising edge
  initial begin
    addr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 addr_ready = rdy_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops on each handshake, checks stability while stalled
  logic [7:0] prev_addr;
  logic       prev_wl;
  bit         stalled = 0;
  always @(negedge clk) begin
    if (!rst && addr_valid) begin
      valid_cyc++;
      if (stalled) begin
        chk("stall_addr_stable", addr, prev_addr);
        chk("stall_winlast_stable", win_last, prev_wl);
      end
      if (addr_ready) begin
        logic [8:0] e;
        hs_cnt++;
        stalled = 0;
        if (exp_q.size() == 0) chk("unexpected_handshake", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("addr", addr, e[7:0]);
          chk("win_last", win_last, e[8]);
        end
      end else begin
        stalled   = 1;
        prev_addr = addr;
        prev_wl   = win_last;
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic drive_cfg(input int cn, input int cm, input int ck, input int cb, input int cs);
    n    = 8'(cn);
    m    = 8'(cm);
    k    = 8'(ck);
    base = 8'(cb);
`ifdef CONV_ADDR_STRIDE_EN
    stride = 2'(cs);
`else
    if (cs != 1) $display("note: stride %0d requested without stride support", cs);
`endif
  endtask

  task automatic run_scan(input int sn, input int sm, input int sk, input int sb, input int ss, input bit rnd);
    int nexp, bad;
    bad = (sk == 0 || sk > sn || sk > sm || ss == 0) ? 1 : 0;
    nexp = exp_q.size();
    model(sn, sm, sk, sb, ss);
    nexp = exp_q.size() - nexp;
    rdy_rnd = rnd;
    @(posedge clk);
    #1;
    hs_cnt = 0;
    valid_cyc = 0;
    done_cyc = 0;
    drive_cfg(sn, sm, sk, sb, ss);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    // Scramble the inputs: the scan must run on the latched values
    drive_cfg($urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255),
              $urandom_range(0, 255), $urandom_range(1, 3));
    for (int cyc = 2; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == 5);   // start during RUN must be ignored
    end
    start = 0;
    chk("done_seen", (done_cyc != 0) ? 1 : 0, 1);
    chk("cfg_err", cfg_err, bad);
    chk("busy_in_done", busy, 0);
    chk("valid_in_done", addr_valid, 0);
    chk("handshakes", hs_cnt, nexp);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_latency", done_cyc, valid_cyc + 2);
    if (!rnd) chk("valid_cycles", valid_cyc, nexp);
    // Start during the DONE cycle must also be ignored
    drive_cfg(4, 4, 2, 0, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("done_one_cycle", done, 0);
    chk("start_in_done_busy", busy, 0);
    chk("start_in_done_valid", addr_valid, 0);
    rdy_rnd = 0;
  endtask

  task automatic check_reset_values();
    chk("rst_addr", addr, 0);
    chk("rst_addr_valid", addr_valid, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
  endtask

  initial begin
    rst = 1;
    start = 0;
    drive_cfg(0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 0;

    // Basic 4x4, k=3, ready tied high
    run_scan(4, 4, 3, 8'h10, 1, 0);
    chk("basic_done_cycle", done_cyc, 38);
    chk("basic_handshakes", hs_cnt, 36);

    // Same config under random back-pressure
    run_scan(4, 4, 3, 8'h10, 1, 1);

    // Illegal: k larger than n
    run_scan(4, 8, 5, 8'h10, 1, 0);
    chk("illegal_no_valid", valid_cyc, 0);

    // Address wrap past 0xFF
    run_scan(8, 8, 2, 8'hF0, 1, 1);

    // Legal start clears cfg_err
    run_scan(3, 3, 3, 8'h00, 1, 0);

    // Reset after 10th handshake
    exp_q.delete();
    model(4, 4, 3, 8'h10, 1);
    rdy_rnd = 0;
    @(posedge clk);
    #1;
    hs_cnt = 0;
    drive_cfg(4, 4, 3, 8'h10, 1);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int i = 0; i < 200 && hs_cnt < 10; i++) @(posedge clk);
    chk("reached_10_handshakes", hs_cnt, 10);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 0;
    exp_q.delete();
    @(negedge clk);
    chk("no_resume_valid", addr_valid, 0);
    chk("no_resume_busy", busy, 0);
    run_scan(4, 4, 3, 8'h10, 1, 1);

`ifdef CONV_ADDR_STRIDE_EN
    run_scan(5, 5, 3, 8'h20, 2, 0);
    chk("stride_handshakes", hs_cnt, 36);
    run_scan(5, 5, 3, 8'h20, 0, 0);
`endif

    // Random configurations, including k=0 and k=1
    for (int t = 0; t < 10; t++) begin
      int rs;
`ifdef CONV_ADDR_STRIDE_EN
      rs = $urandom_range(0, 3);
`else
      rs = 1;
`endif
      run_scan($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(0, 5),
               $urandom_range(0, 255), rs, $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
